// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : 8N1 UART receiver with valid/ready byte output and error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int                 C_HALF     = CLKS_PER_BIT / 2;
    localparam int                 C_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [C_CNT_W-1:0] C_HALF_END = C_CNT_W'(C_HALF - 1);
    localparam logic [C_CNT_W-1:0] C_BIT_END  = C_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_WAIT_HIGH = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4
    } state_t;

    logic               r_rxd_m;
    logic               r_rxd_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [7:0]         r_sh;
    logic [7:0]         w_sh_nxt;
    logic               w_load;
    logic               w_ovr;
    logic               w_ferr;
    logic               w_buf_free;

    // Synchroniser resets to the idle line level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rxd_m <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_rxd_m <= rxd;
            r_rxd_s <= r_rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_WAIT_HIGH;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sh    <= w_sh_nxt;
        end
    end

    // A byte being consumed this cycle frees the buffer for a same-cycle reload
    assign w_buf_free = !rx_valid || rx_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_load      = 1'b0;
        w_ovr       = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_WAIT_HIGH: begin
                if (r_rxd_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!r_rxd_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == C_HALF_END) begin
                    w_cnt_nxt = '0;
                    if (!r_rxd_s) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == C_BIT_END) begin
                    w_cnt_nxt = '0;
                    w_sh_nxt  = {r_rxd_s, r_sh[7:1]};
                    w_idx_nxt = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == C_BIT_END) begin
                    w_cnt_nxt = '0;
                    if (r_rxd_s) begin
                        w_state_nxt = S_IDLE;
                        if (w_buf_free) begin
                            w_load = 1'b1;
                        end else begin
                            w_ovr = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_WAIT_HIGH;
                        w_ferr      = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_HIGH;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_ferr;
            overrun   <= w_ovr;
            if (w_load) begin
                rx_data  <= r_sh;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Directed scoreboard bench for uart_rx_core at 16 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         total  = 0;
    int         bad    = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] sb_q[$];

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop_bit;
        tick(CPB);
    endtask

    // Handshake scoreboard and flag counters, sampled mid-cycle
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err || overrun) chk("flag_excl", 32'(frame_err & overrun), 32'd0);
        if (rx_valid && rx_ready) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            else chk("rx_data_sb", 32'(rx_data), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        int ov0;
        int busy_hi;
        rstn     = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        chk("rst_data",  32'(rx_data),   32'd0);
        chk("rst_valid", 32'(rx_valid),  32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_ovr",   32'(overrun),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rstn = 1'b1;
        tick(5);

        // 0xA5 with exact latency
        rx_ready = 1'b1;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        sb_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(154);
                chk("lat_early", 32'(rx_valid), 32'd0);
                tick(1);
                chk("lat_valid", 32'(rx_valid), 32'd1);
                chk("lat_data",  32'(rx_data),  32'hA5);
            end
        join
        tick(4);
        chk("a5_ferr",    32'(fe_cnt - fe0), 32'd0);
        chk("a5_ovr",     32'(ov_cnt - ov0), 32'd0);
        chk("a5_drained", 32'(rx_valid),     32'd0);

        // 4-cycle glitch
        rxd = 1'b0;
        tick(4);
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        rxd = 1'b1;
        tick(HALF + 2);
        chk("glitch_busy_lo", 32'(busy),          32'd0);
        chk("glitch_valid",   32'(rx_valid),      32'd0);
        chk("glitch_ferr",    32'(fe_cnt - fe0),  32'd0);

        // Framing error followed by a stuck-low line
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        busy_hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (busy) busy_hi++;
        end
        chk("fe_no_restart", 32'(busy_hi),      32'd0);
        chk("fe_pulse",      32'(fe_cnt - fe0), 32'd1);
        chk("fe_valid",      32'(rx_valid),     32'd0);
        rxd = 1'b1;
        tick(10);
        chk("fe_recover_busy", 32'(busy), 32'd0);

        // Overrun with sink stalled
        rx_ready = 1'b0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        chk("ovr_first_valid", 32'(rx_valid), 32'd1);
        chk("ovr_first_data",  32'(rx_data),  32'h11);
        send_frame(8'h22, 1'b1);
        chk("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
        chk("ovr_hold",  32'(rx_data),      32'h11);
        chk("ovr_valid", 32'(rx_valid),     32'd1);
        chk("ovr_ferr",  32'(fe_cnt - fe0), 32'd0);
        rx_ready = 1'b1;
        tick(2);
        chk("ovr_consumed", 32'(rx_valid), 32'd0);
        rx_ready = 1'b0;

        // Back-to-back 0x00, 0xFF with pulsed ready
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        sb_q.push_back(8'h00);
        sb_q.push_back(8'hFF);
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    int w;
                    w = 0;
                    while (!rx_valid && w < 400) begin
                        tick(1);
                        w++;
                    end
                    chk("b2b_wait", 32'(rx_valid), 32'd1);
                    rx_ready = 1'b1;
                    tick(1);
                    rx_ready = 1'b0;
                end
            end
        join
        tick(5);
        chk("b2b_ferr",  32'(fe_cnt - fe0), 32'd0);
        chk("b2b_ovr",   32'(ov_cnt - ov0), 32'd0);
        chk("b2b_valid", 32'(rx_valid),     32'd0);

        // Reset mid-DATA on a low line
        rx_ready = 1'b1;
        rxd = 1'b0;
        tick(CPB + 40);
        rstn = 1'b0;
        tick(2);
        chk("mid_rst_data",  32'(rx_data),   32'd0);
        chk("mid_rst_valid", 32'(rx_valid),  32'd0);
        chk("mid_rst_ferr",  32'(frame_err), 32'd0);
        chk("mid_rst_ovr",   32'(overrun),   32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        rstn = 1'b1;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        tick(1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        tick(2);
        rxd = 1'b1;
        tick(20);
        chk("post_rst_idle", 32'(busy), 32'd0);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(5);
        chk("post_rst_ferr", 32'(fe_cnt - fe0),  32'd0);
        chk("post_rst_ovr",  32'(ov_cnt - ov0),  32'd0);
        chk("sb_empty",      32'(sb_q.size()),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
